ibex_instr_mem_responder: RTL and testbench

// - Memory-side responder for the core instruction bus (req/gnt/rvalid). Produces the in_valid/
//   in_rdata/in_err stream that the prefetch buffer and fetch FIFO consume.
// - Word-addressed SRAM model with a backdoor load port, fixed response latency, bounded

---
 rtl/ibex_instr_resp_pkg.sv | 29 ++
 rtl/ibex_instr_mem_responder_if.sv | 32 +++
 rtl/ibex_instr_resp_queue.sv | 80 ++++++++
 rtl/ibex_instr_mem_responder.sv | 110 +++++++++++
 tb/tb_ibex_instr_mem_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_instr_resp_pkg.sv
// Shared types and helpers for the instruction-bus memory responder.
// - resp_entry_t : one queued response (read data, error flag, latency down-counter)
// - LfsrSeed/LfsrTaps : stall-generator LFSR constants (IBEX_INSTR_RESP_STALL_EN builds)
// - addr_in_range : byte-address window check against the memory image
package ibex_instr_resp_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  cnt;
  } resp_entry_t;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Taps 8,6,5,4 of a 1-based Fibonacci LFSR map to bits 7,5,4,3.
  localparam logic [7:0] LfsrTaps = 8'hB8;

  // Widened to 34 bits so a window ending at the top of the address space does not wrap.
  function automatic logic addr_in_range(logic [31:0] addr, logic [31:0] base,
                                         int unsigned size_words);
    logic [33:0] a;
    logic [33:0] lo;
    logic [33:0] hi;
    a  = {2'b00, addr};
    lo = {2'b00, base};
    hi = lo + {size_words, 2'b00};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/ibex_instr_mem_responder_if.sv
// Instruction bus between a requester (core fetch side) and a memory responder.
// - req/addr   : requester -> responder
// - gnt        : responder -> requester, request accepted this cycle
// - rvalid/rdata/err : responder -> requester, one response per granted request, in order
interface ibex_instr_mem_responder_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );

endinterface

// File: rtl/ibex_instr_resp_queue.sv
// In-order response queue for granted instruction fetches.
// - push_i/push_data_i : enqueue an entry (cnt already loaded with latency-1)
// - pop_i              : dequeue the head (caller pops only when head_ready_o)
// - count_o            : number of queued entries
// - head_ready_o       : queue non-empty and head counter expired
// - head_rdata_o/head_err_o : head entry payload
module ibex_instr_resp_queue
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  resp_entry_t push_data_i,
  input  logic        pop_i,
  output logic [2:0]  count_o,
  output logic        head_ready_o,
  output logic [31:0] head_rdata_o,
  output logic        head_err_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  resp_entry_t entries_q [Depth];
  resp_entry_t entries_d [Depth];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  resp_entry_t head;

  function automatic ptr_t ptr_inc(ptr_t p);
    if (p == ptr_t'(Depth - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  always_comb begin
    entries_d = entries_q;
    // Every slot counts down independently; a freshly pushed entry overrides its slot.
    for (int i = 0; i < Depth; i++) begin
      if (entries_q[i].cnt != 3'd0) begin
        entries_d[i].cnt = entries_q[i].cnt - 3'd1;
      end
    end
    if (push_i) begin
      entries_d[wr_ptr_q] = push_data_i;
    end
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + {2'b00, push_i} - {2'b00, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    head         = entries_q[rd_ptr_q];
    count_o      = count_q;
    head_ready_o = (count_q != 3'd0) && (head.cnt == 3'd0);
    head_rdata_o = head.rdata;
    head_err_o   = head.err;
  end

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for the core instruction bus (req/gnt/rvalid).
// Word-addressed SRAM with a backdoor write port, fixed response latency, bounded outstanding
// requests and in-order responses.
// Ports:
// - clk_i, rst_ni      : clock, asynchronous active-low reset
// - bus_io (slave)     : req/addr in, gnt/rvalid/rdata/err out
// - mem_we_i/mem_waddr_i/mem_wdata_i : backdoor word write
// - stall_o            : only with IBEX_INSTR_RESP_STALL_EN, current pseudo-random stall
// Optional feature macro: IBEX_INSTR_RESP_STALL_EN (LFSR-driven grant stalls).
module ibex_instr_mem_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned MemSizeWords   = 1024,
  parameter logic [31:0] AddrBase       = 32'h0000_0000,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1,
  localparam int unsigned AddrW         = $clog2(MemSizeWords)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  ibex_instr_mem_responder_if.slave bus_io,
  input  logic             mem_we_i,
  input  logic [AddrW-1:0] mem_waddr_i,
  input  logic [31:0]      mem_wdata_i
`ifdef IBEX_INSTR_RESP_STALL_EN
  ,
  output logic             stall_o
`endif
);

  logic [31:0] mem_q [MemSizeWords];

  logic             in_range;
  logic [AddrW-1:0] word_idx;
  logic             stall;
  logic             gnt;
  resp_entry_t      push_entry;
  logic [2:0]       count;
  logic             head_ready;
  logic [31:0]      head_rdata;
  logic             head_err;

  // Backdoor write lands at the edge, so a same-cycle grant reads the old word.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      mem_q[mem_waddr_i] <= mem_wdata_i;
    end
  end

  // AddrBase is aligned to the memory size, so its low index bits are zero.
  assign word_idx = bus_io.addr[AddrW+1:2];
  assign in_range = addr_in_range(bus_io.addr, AddrBase, MemSizeWords);

`ifdef IBEX_INSTR_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus_io.req) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall   = (lfsr_q[1:0] == 2'b00);
  assign stall_o = stall;
`else
  assign stall = 1'b0;
`endif

  // Capacity uses the registered count: a pop in a full cycle does not free a slot until the
  // next cycle. rst_ni gates grant so nothing is accepted while held in reset.
  assign gnt = rst_ni & bus_io.req & (count < 3'(MaxOutstanding)) & ~stall;

  always_comb begin
    push_entry.rdata = in_range ? mem_q[word_idx] : 32'h0;
    push_entry.err   = ~in_range;
    push_entry.cnt   = 3'(RespLatency - 1);
  end

  ibex_instr_resp_queue #(
    .Depth (MaxOutstanding)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (gnt),
    .push_data_i  (push_entry),
    .pop_i        (head_ready),
    .count_o      (count),
    .head_ready_o (head_ready),
    .head_rdata_o (head_rdata),
    .head_err_o   (head_err)
  );

  // Response fields come straight from queue flops, so they are registered outputs.
  always_comb begin
    bus_io.gnt    = gnt;
    bus_io.rvalid = head_ready;
    bus_io.rdata  = head_ready ? head_rdata : 32'h0;
    bus_io.err    = head_ready & head_err;
  end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench for ibex_instr_mem_responder.
// u_dut0: defaults (1024 words, base 0, 2 outstanding, latency 1), driven from a vector table.
// u_dut3: 16 words at 0x1000, 2 outstanding, latency 3, driven by hand-written sequences.
module tb_ibex_instr_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ibex_instr_mem_responder_if u_if0 ();
  ibex_instr_mem_responder_if u_if3 ();

  logic        we0, we3;
  logic [9:0]  waddr0;
  logic [3:0]  waddr3;
  logic [31:0] wdata0, wdata3;
`ifdef IBEX_INSTR_RESP_STALL_EN
  logic        stall0, stall3;
`endif

  ibex_instr_mem_responder u_dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_io      (u_if0),
    .mem_we_i    (we0),
    .mem_waddr_i (waddr0),
    .mem_wdata_i (wdata0)
`ifdef IBEX_INSTR_RESP_STALL_EN
    ,
    .stall_o     (stall0)
`endif
  );

  ibex_instr_mem_responder #(
    .MemSizeWords   (16),
    .AddrBase       (32'h0000_1000),
    .MaxOutstanding (2),
    .RespLatency    (3)
  ) u_dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_io      (u_if3),
    .mem_we_i    (we3),
    .mem_waddr_i (waddr3),
    .mem_wdata_i (wdata3)
`ifdef IBEX_INSTR_RESP_STALL_EN
    ,
    .stall_o     (stall3)
`endif
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_resp0(input string tag, input logic g, input logic v, input logic [31:0] d,
                           input logic e);
    chk({tag, " gnt0"}, {31'h0, u_if0.gnt}, {31'h0, g});
    chk({tag, " rvalid0"}, {31'h0, u_if0.rvalid}, {31'h0, v});
    chk({tag, " rdata0"}, u_if0.rdata, d);
    chk({tag, " err0"}, {31'h0, u_if0.err}, {31'h0, e});
  endtask

  task automatic chk_resp3(input string tag, input logic g, input logic v, input logic [31:0] d,
                           input logic e);
    chk({tag, " gnt3"}, {31'h0, u_if3.gnt}, {31'h0, g});
    chk({tag, " rvalid3"}, {31'h0, u_if3.rvalid}, {31'h0, v});
    chk({tag, " rdata3"}, u_if3.rdata, d);
    chk({tag, " err3"}, {31'h0, u_if3.err}, {31'h0, e});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // req/addr, backdoor write | expected gnt, rvalid, rdata, err
    vecs[0]  = '{1'b1, 32'h0000_0014, 1'b0, 10'd0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_1000, 1'b0, 10'd0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_001C, 1'b0, 10'd0, 32'h0,   1'b1, 1'b1, 32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0008, 1'b1, 10'd2, 32'h1,   1'b1, 1'b1, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0008, 1'b1, 10'd2, 32'h2,   1'b1, 1'b1, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0FFC, 1'b0, 10'd0, 32'h0,   1'b1, 1'b1, 32'h1,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0016, 1'b0, 10'd0, 32'h0,   1'b1, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 10'd0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h0000_0008, 1'b0, 10'd0, 32'h0,   1'b1, 1'b1, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,   1'b0, 1'b1, 32'h2,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0};

    rst_n = 1'b0;
    u_if0.req = 1'b1;  u_if0.addr = 32'h14;
    u_if3.req = 1'b1;  u_if3.addr = 32'h1000;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we3 = 1'b0; waddr3 = '0; wdata3 = '0;

    // Held in reset with req=1: nothing granted or answered; backdoor preload meanwhile.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      we0 = 1'b1;
      case (i)
        0:       begin waddr0 = 10'd5;    wdata0 = 32'hDEAD_BEEF; end
        1:       begin waddr0 = 10'd2;    wdata0 = 32'h0;         end
        2:       begin waddr0 = 10'd7;    wdata0 = 32'h1234_5678; end
        3:       begin waddr0 = 10'd1023; wdata0 = 32'hCAFE_F00D; end
        default: begin waddr0 = 10'd5;    wdata0 = 32'hDEAD_BEEF; end
      endcase
      we3 = 1'b1; waddr3 = 4'(i); wdata3 = 32'hA0 + 32'(i);
      @(negedge clk);
      if (i == 0 || i == 5) begin
        chk_resp0("in_reset", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_resp3("in_reset", 1'b0, 1'b0, 32'h0, 1'b0);
      end
    end

`ifndef IBEX_INSTR_RESP_STALL_EN
    // Vector table on u_dut0; row 0 is the first cycle after reset release.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        rst_n = 1'b1;
        u_if3.req = 1'b0;
        we3 = 1'b0;
      end
      u_if0.req = vecs[i].req;  u_if0.addr = vecs[i].addr;
      we0 = vecs[i].we;  waddr0 = vecs[i].waddr;  wdata0 = vecs[i].wdata;
      @(negedge clk);
      chk_resp0($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].err);
    end

    // Latency 3, two outstanding, req held: gnt 1,1,0,0 repeating; rvalid 3 cycles after gnt.
    // A backdoor write to word 0 while its read is queued must not change the response.
    begin
      logic [15:0] eg;
      logic [15:0] ev;
      int ng;
      int nr;
      eg = 16'h0333;
      ev = 16'h1998;
      ng = 0;
      nr = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        u_if3.req  = (c < 12);
        u_if3.addr = 32'h1000 + 32'(4 * ng);
        we3 = (c == 1); waddr3 = 4'd0; wdata3 = 32'hFF;
        @(negedge clk);
        if (ev[c]) begin
          chk_resp3($sformatf("lat3 c%0d", c), eg[c], 1'b1, 32'hA0 + 32'(nr), 1'b0);
          nr++;
        end else begin
          chk_resp3($sformatf("lat3 c%0d", c), eg[c], 1'b0, 32'h0, 1'b0);
        end
        if (u_if3.gnt) ng++;
      end
      we3 = 1'b0;
    end

    // Below-base and past-end addresses error out; the following in-range read is clean.
    begin
      logic [31:0] al [3];
      logic [31:0] dl [3];
      logic        el [3];
      logic [8:0]  eg;
      logic [8:0]  ev;
      int ng;
      int nr;
      al[0] = 32'h0000_0FFC; dl[0] = 32'h0;  el[0] = 1'b1;
      al[1] = 32'h0000_1040; dl[1] = 32'h0;  el[1] = 1'b1;
      al[2] = 32'h0000_1004; dl[2] = 32'hA1; el[2] = 1'b0;
      eg = 9'h013;
      ev = 9'h098;
      ng = 0;
      nr = 0;
      for (int c = 0; c < 9; c++) begin
        @(posedge clk); #1;
        u_if3.req  = (ng < 3);
        u_if3.addr = (ng < 3) ? al[ng] : 32'h0;
        @(negedge clk);
        if (ev[c]) begin
          chk_resp3($sformatf("range c%0d", c), eg[c], 1'b1, dl[nr], el[nr]);
          nr++;
        end else begin
          chk_resp3($sformatf("range c%0d", c), eg[c], 1'b0, 32'h0, 1'b0);
        end
        if (u_if3.gnt) ng++;
      end
    end

    // Reset with two reads pending: they vanish; first request after release is granted at
    // once and answered 3 cycles later.
    begin
      logic [9:0] eg;
      logic [9:0] ev;
      eg = 10'h023;
      ev = 10'h100;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        rst_n = !(c >= 2 && c <= 4);
        u_if3.req  = (c <= 5);
        u_if3.addr = (c <= 4) ? 32'h1008 : 32'h100C;
        @(negedge clk);
        chk_resp3($sformatf("rst c%0d", c), eg[c], ev[c], ev[c] ? 32'hA3 : 32'h0, 1'b0);
      end
    end
`else
    // Stall build: grant tracks an independent LFSR model, every grant is answered.
    begin
      logic [7:0] m;
      logic       st;
      int ng;
      int nr;
      m  = 8'hA5;
      ng = 0;
      nr = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      u_if3.req = 1'b0;
      we0 = 1'b0;
      we3 = 1'b0;
      u_if0.addr = 32'h14;
      for (int c = 0; c < 66; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
        end
        u_if0.req = (c < 64);
        @(negedge clk);
        st = (m[1:0] == 2'b00);
        chk($sformatf("stall c%0d", c), {31'h0, stall0}, {31'h0, st});
        chk($sformatf("stall gnt c%0d", c), {31'h0, u_if0.gnt}, {31'h0, (c < 64) && !st});
        if (u_if0.rvalid) begin
          chk($sformatf("stall rdata c%0d", c), u_if0.rdata, 32'hDEAD_BEEF);
          nr++;
        end
        if (u_if0.gnt) ng++;
        if (u_if0.req) m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      end
      chk("stall rvalid count", 32'(nr), 32'(ng));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
